program_loader: RTL

Bus master that writes a program image into the processor's RAM through the RAM's own address-latch/write port (MI/RI/write bus) while holding the processor in reset. It accepts a word stream (start address, word count, data words) over a valid/ready handshake. It writes the data words to consecutive RAM addresses, then writes the boot vector to RAM word 0 and releases the processor. It sits between an external host link and the RAM bus mux. The top level selects the loader's MI/RI/write outputs while `cpu_hold` is high.

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Host-stream and RAM-bus signals of the program loader, grouped for port binding.
// slave = loader view, master = host/RAM-side view.
interface program_loader_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             MI;
  logic             RI;
  logic [WIDTH-1:0] write;
  logic             cpu_hold;
  logic             done;
  logic [2:0]       dbg_state;

  modport slave (
    input  in_data, in_valid,
    output in_ready, MI, RI, write, cpu_hold, done, dbg_state
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, MI, RI, write, cpu_hold, done, dbg_state
  );
endinterface

// File: rtl/program_loader.sv
// Loads a streamed program image into RAM over the MI/RI/write bus, then writes
// the boot vector and releases the processor from reset.
module program_loader #(
  parameter int          WIDTH       = 16,
  parameter int unsigned VECTOR_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);
  // Stream handshake: a word transfers on a posedge where in_valid && in_ready.
  // in_ready is registered, so the host never sees a combinational path.
  typedef enum logic [2:0] {
    S_HDR_ADDR  = 3'd0,
    S_HDR_CNT   = 3'd1,
    S_DATA_WAIT = 3'd2,
    S_WR_ADDR   = 3'd3,
    S_WR_DATA   = 3'd4,
    S_VEC_ADDR  = 3'd5,
    S_VEC_DATA  = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_write;
  logic             r_in_ready;
  logic             r_mi;
  logic             r_ri;
  logic             r_cpu_hold;
  logic             r_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_rem_dec;
  logic [WIDTH-1:0] w_write;
  logic             w_in_ready;
  logic             w_mi;
  logic             w_ri;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_rem_dec = r_remaining - WIDTH'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_ADDR:  if (w_accept) w_next = S_HDR_CNT;
      S_HDR_CNT:   if (w_accept) w_next = (bus.in_data == '0) ? S_VEC_ADDR : S_DATA_WAIT;
      S_DATA_WAIT: if (w_accept) w_next = S_WR_ADDR;
      S_WR_ADDR:   w_next = S_WR_DATA;
      S_WR_DATA:   w_next = (w_rem_dec == '0) ? S_VEC_ADDR : S_DATA_WAIT;
      S_VEC_ADDR:  w_next = S_VEC_DATA;
      S_VEC_DATA:  w_next = S_DONE;
      S_DONE:      w_next = S_DONE;
      default:     w_next = S_HDR_ADDR;
    endcase
  end

  // Outputs are decoded from the next state so they are valid registers in that state.
  always_comb begin
    w_in_ready = 1'b0;
    w_mi       = 1'b0;
    w_ri       = 1'b0;
    w_write    = '0;
    case (w_next)
      S_HDR_ADDR, S_HDR_CNT, S_DATA_WAIT: w_in_ready = 1'b1;
      S_WR_ADDR: begin
        w_mi    = 1'b1;
        w_write = r_ptr;
      end
      S_WR_DATA: begin
        w_ri    = 1'b1;
        w_write = r_data;
      end
      S_VEC_ADDR: begin
        w_mi    = 1'b1;
        w_write = WIDTH'(VECTOR_ADDR);
      end
      S_VEC_DATA: begin
        // The CPU pre-increments the fetched PC, so base-1 makes the first fetch hit base.
        w_ri    = 1'b1;
        w_write = r_base - WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HDR_ADDR;
      r_base      <= '0;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_write     <= '0;
      r_in_ready  <= 1'b1;
      r_mi        <= 1'b0;
      r_ri        <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_write    <= w_write;
      r_in_ready <= w_in_ready;
      r_mi       <= w_mi;
      r_ri       <= w_ri;
      r_cpu_hold <= (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      case (r_state)
        S_HDR_ADDR: if (w_accept) begin
          r_base <= bus.in_data;
          r_ptr  <= bus.in_data;
        end
        S_HDR_CNT:   if (w_accept) r_remaining <= bus.in_data;
        S_DATA_WAIT: if (w_accept) r_data <= bus.in_data;
        S_WR_DATA: begin
          r_ptr       <= r_ptr + WIDTH'(1);
          r_remaining <= w_rem_dec;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.MI        = r_mi;
  assign bus.RI        = r_ri;
  assign bus.write     = r_write;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
endmodule
